// File: rtl/proc_mem_pkg.sv
// Shared definitions for the processor's data-memory port: load/store
// encoding, bus widths, responder FSM states and the latched request record.
package proc_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    // Codebase encoding of the Save line: high means load.
    localparam logic LD = 1'b1;
    localparam logic SD = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic              save;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W register file: synchronous write, registered read, async
// clear to zero with one preloaded word.
module dmem_array
    import proc_mem_pkg::*;
#(
    parameter int                DEPTH     = 16,
    parameter int                INIT_ADDR = 3,
    parameter logic [DATA_W-1:0] INIT_DATA = 16'h0004,
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic              rd_zero,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;

    // rd_zero lets the caller return zero for an out-of-range load while
    // still updating the read register in the same cycle.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
        if (re) begin
            rdata_d = rd_zero ? '0 : mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == INIT_ADDR) ? INIT_DATA : '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one request, stalls WAIT_STATES cycles,
// performs the access and pulses Ack for one cycle (AddrErr qualifies it).
module dmem_responder
    import proc_mem_pkg::*;
#(
    parameter int                DEPTH       = 16,
    parameter int                WAIT_STATES = 2,
    parameter int                INIT_ADDR   = 3,
    parameter logic [DATA_W-1:0] INIT_DATA   = 16'h0004
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Req,
    input  logic              Save,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              Ack,
    output logic              Busy,
    output logic              AddrErr
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             addr_err_q, addr_err_d;

    logic access;
    logic in_range;
    logic mem_we;
    logic mem_re;

    assign in_range = addr_in_range(req_q.addr, DEPTH);

    // Only the latched request is used after accept, so the core's bus may
    // wander during WAIT without effect.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        addr_err_d = 1'b0;
        access     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Req) begin
                    req_d   = '{save: Save, addr: Addr, wdata: WrData};
                    cnt_d   = CNT_W'(WAIT_STATES);
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access     = 1'b1;
                    ack_d      = 1'b1;
                    busy_d     = 1'b0;
                    addr_err_d = !in_range;
                    state_d    = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Out-of-range stores are dropped; out-of-range loads read back zero.
    assign mem_we = access && (req_q.save == SD) && in_range;
    assign mem_re = access && (req_q.save == LD);

    dmem_array #(
        .DEPTH     (DEPTH),
        .INIT_ADDR (INIT_ADDR),
        .INIT_DATA (INIT_DATA)
    ) u_array (
        .clk     (Clock),
        .rst_n   (Resetn),
        .we      (mem_we),
        .re      (mem_re),
        .rd_zero (!in_range),
        .addr    (req_q.addr[AW-1:0]),
        .wdata   (req_q.wdata),
        .rdata   (RdData)
    );

    assign Ack     = ack_q;
    assign Busy    = busy_q;
    assign AddrErr = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_STATES=2 build and a WAIT_STATES=0 build
// share one request stream; directed table, corner sequences, random vs model.
module tb_dmem_responder;
    import proc_mem_pkg::*;

    localparam int DEPTH = 16;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic        Req    = 1'b0;
    logic        Save   = 1'b0;
    logic [15:0] Addr   = '0;
    logic [15:0] WrData = '0;
    logic [15:0] RdData, RdData_z;
    logic        Ack, Busy, AddrErr;
    logic        Ack_z, Busy_z, AddrErr_z;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    dmem_responder #(
        .DEPTH(DEPTH), .WAIT_STATES(2), .INIT_ADDR(3), .INIT_DATA(16'h0004)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Req(Req), .Save(Save), .Addr(Addr),
        .WrData(WrData), .RdData(RdData), .Ack(Ack), .Busy(Busy), .AddrErr(AddrErr)
    );

    dmem_responder #(
        .DEPTH(DEPTH), .WAIT_STATES(0), .INIT_ADDR(3), .INIT_DATA(16'h0004)
    ) dut_z (
        .Clock(Clock), .Resetn(Resetn), .Req(Req), .Save(Save), .Addr(Addr),
        .WrData(WrData), .RdData(RdData_z), .Ack(Ack_z), .Busy(Busy_z),
        .AddrErr(AddrErr_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain word array plus the last load result.
    logic [15:0] mmem [DEPTH];
    logic [15:0] mrd;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        mmem[3] = 16'h0004;
        mrd     = '0;
    endtask

    task automatic model_txn(input logic save, input logic [15:0] addr,
                             input logic [15:0] wdata,
                             output logic [15:0] exp_rd, output logic exp_err);
        exp_err = (int'(addr) >= DEPTH);
        if (save == LD) mrd = exp_err ? 16'h0 : mmem[addr % DEPTH];
        else if (!exp_err) mmem[addr % DEPTH] = wdata;
        exp_rd = mrd;
    endtask

    // One request; bus is scrambled right after accept. Latencies are in
    // edges after the accept edge; 0 means no Ack within the budget.
    task automatic do_txn(input logic save, input logic [15:0] addr,
                          input logic [15:0] wdata,
                          output logic [15:0] rd, output logic err, output int lat,
                          output logic [15:0] zrd, output logic zerr, output int zlat);
        rd = '0; err = 1'b0; lat = 0; zrd = '0; zerr = 1'b0; zlat = 0;
        @(negedge Clock);
        Req = 1'b1; Save = save; Addr = addr; WrData = wdata;
        @(posedge Clock);
        #1;
        Req = 1'b0; Save = ~save; Addr = 16'($urandom); WrData = 16'($urandom);
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clock);
            #1;
            if (Ack_z && zlat == 0) begin
                zlat = n; zrd = RdData_z; zerr = AddrErr_z;
            end
            if (Ack) begin
                lat = n; rd = RdData; err = AddrErr;
                break;
            end
        end
    endtask

    task automatic run_txn(input string name, input logic save, input logic [15:0] addr,
                           input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input logic exp_err);
        logic [15:0] rd, zrd;
        logic        err, zerr;
        int          lat, zlat;
        do_txn(save, addr, wdata, rd, err, lat, zrd, zerr, zlat);
        chk({name, " lat"}, lat, 3);
        chk({name, " rd"}, rd, exp_rd);
        chk({name, " err"}, err, exp_err);
        chk({name, " ws0 lat"}, zlat, 1);
        chk({name, " ws0 rd"}, zrd, exp_rd);
        chk({name, " ws0 err"}, zerr, exp_err);
    endtask

    typedef struct {
        logic        save;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [15:0] erd;
        logic        eerr;
        logic        saw_ack;

        vecs[0]  = '{LD, 16'h0003, 16'h0000, 16'h0004, 1'b0};
        vecs[1]  = '{SD, 16'h0007, 16'hBEEF, 16'h0004, 1'b0};
        vecs[2]  = '{LD, 16'h0007, 16'h0000, 16'hBEEF, 1'b0};
        vecs[3]  = '{SD, 16'h0020, 16'h1234, 16'hBEEF, 1'b1};
        vecs[4]  = '{LD, 16'h0020, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{LD, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[6]  = '{SD, 16'h000F, 16'hABCD, 16'h0000, 1'b0};
        vecs[7]  = '{LD, 16'h000F, 16'h0000, 16'hABCD, 1'b0};
        vecs[8]  = '{LD, 16'h0010, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{LD, 16'h0007, 16'h0000, 16'hBEEF, 1'b0};
        vecs[10] = '{SD, 16'h8003, 16'h1111, 16'hBEEF, 1'b1};
        vecs[11] = '{LD, 16'h0003, 16'h0000, 16'h0004, 1'b0};

        // Reset state
        #12;
        chk("rst rd", RdData, 16'h0);
        chk("rst ack", Ack, 1'b0);
        chk("rst busy", Busy, 1'b0);
        chk("rst err", AddrErr, 1'b0);
        chk("rst ws0 busy", Busy_z, 1'b0);
        @(negedge Clock);
        Resetn = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].save, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err);
        end

        // Req held high: accepts in DONE, Acks every 4 cycles
        @(negedge Clock);
        Req = 1'b1; Save = LD; Addr = 16'h0003; WrData = 16'h0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("b2b ack k%0d", k), Ack, (k % 4) == 3);
            chk($sformatf("b2b busy k%0d", k), Busy, (k % 4) != 3);
            if (k == 10) Req = 1'b0;
        end
        chk("b2b rd", RdData, 16'h0004);

        // Reset during WAIT of a store to 5
        @(negedge Clock);
        Req = 1'b1; Save = SD; Addr = 16'h0005; WrData = 16'h7777;
        @(posedge Clock);
        #1;
        Req = 1'b0;
        @(posedge Clock);
        #1;
        chk("midrst busy before", Busy, 1'b1);
        Resetn = 1'b0;
        #2;
        chk("midrst ack", Ack, 1'b0);
        chk("midrst busy", Busy, 1'b0);
        chk("midrst rd", RdData, 16'h0);
        @(negedge Clock);
        Resetn = 1'b1;
        model_reset();
        saw_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock);
            #1;
            if (Ack) saw_ack = 1'b1;
        end
        chk("midrst no ack", saw_ack, 1'b0);
        model_txn(LD, 16'h0005, 16'h0, erd, eerr);
        run_txn("midrst ld5", LD, 16'h0005, 16'h0, erd, eerr);
        chk("midrst mem5 const", erd, 16'h0000);
        model_txn(LD, 16'h0003, 16'h0, erd, eerr);
        run_txn("midrst ld3", LD, 16'h0003, 16'h0, erd, eerr);
        chk("midrst mem3 const", erd, 16'h0004);

        // Random traffic against the model
        for (int t = 0; t < 80; t++) begin
            logic        s;
            logic [15:0] a, d;
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            d = 16'($urandom);
            model_txn(s, a, d, erd, eerr);
            run_txn($sformatf("rnd%0d", t), s, a, d, erd, eerr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
